// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial program loader.
package loader_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        ACK  = 3'd2,
        ERR  = 3'd3,
        FIN  = 3'd4,
        HALT = 3'd5
    } state_e;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'h55;

    // Byte position within a 4-byte big-endian word.
    localparam int unsigned BCNT_W = 2;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/byte_assembler.sv
// Four-byte big-endian word assembler; used for both the count and the data words.
module byte_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam logic [BCNT_W-1:0] LAST_BYTE = '1;

    // Only the first three bytes are stored; the fourth arrives on din.
    logic [23:0]       shift_q;
    logic [BCNT_W-1:0] cnt_q;

    // Shift in one byte per enable and track its position in the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            shift_q <= {shift_q[15:0], din};
            cnt_q   <= cnt_q + BCNT_W'(1);
        end
    end

    assign word_c       = {shift_q, din};
    assign word_valid_c = en && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: count + big-endian words into instruction memory, then ack.
module uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              error
);

    // Index is one bit wider than the address so a full-memory load does not wrap.
    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    state_e             state_q, state_d;
    logic [31:0]        count_q, count_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_inc;

    logic [7:0]         tx_data_d;
    logic               tx_start_d;
    logic               mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [31:0]        mem_wdata_d;
    logic               done_d;
    logic               error_d;

    logic               asm_en;
    logic [WORD_W-1:0]  asm_word_c;
    logic               asm_valid_c;

    // A framing error discards the byte it arrived with.
    assign asm_en  = rx_ready && !rx_ferr && ((state_q == LEN) || (state_q == DATA));
    assign idx_inc = idx_q + IDX_W'(1);

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .en           (asm_en),
        .din          (rx_data),
        .word_c       (asm_word_c),
        .word_valid_c (asm_valid_c)
    );

    // State, counters and all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LEN;
            count_q   <= '0;
            idx_q     <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            tx_data   <= tx_data_d;
            tx_start  <= tx_start_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data;
        tx_start_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        done_d      = done;
        error_d     = error;

        case (state_q)
            LEN: begin
                if (rx_ferr) begin
                    state_d = ERR;
                end else if (asm_valid_c) begin
                    count_d = asm_word_c;
                    if (asm_word_c == 32'd0) begin
                        state_d = ACK;
                    end else if ({1'b0, asm_word_c} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_ferr) begin
                    state_d = ERR;
                end else if (asm_valid_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q[ADDR_W-1:0];
                    mem_wdata_d = asm_word_c;
                    idx_d       = idx_inc;
                    if (32'(idx_inc) == count_q) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (!tx_busy) begin
                    tx_data_d  = ACK_BYTE;
                    tx_start_d = 1'b1;
                    state_d    = FIN;
                end
            end
            ERR: begin
                if (!tx_busy) begin
                    tx_data_d  = ERR_BYTE;
                    tx_start_d = 1'b1;
                    state_d    = HALT;
                end
            end
            FIN: begin
                done_d = 1'b1;
            end
            HALT: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = LEN;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader (ADDR_W=4 so full-memory and oversize cases are short).
module tb_uart_loader;

    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_ferr;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              error;

    wr_t        wq[$];
    logic [7:0] txq[$];

    int tests_run = 0;
    int fails     = 0;
    int wr_seen   = 0;
    int tx_seen   = 0;

    uart_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_ferr   (rx_ferr),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory write and tx scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] b;
        if (!rst && mem_we === 1'b1) begin
            wr_seen++;
            tests_run++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = wq.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    fails++;
                    $display("FAIL mem_write: got %0h@%0h, expected %0h@%0h", mem_wdata, mem_addr, e.data, e.addr);
                end
            end
        end
        if (!rst && tx_start === 1'b1) begin
            tx_seen++;
            tests_run++;
            if (txq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tx: got byte %02h, expected no tx_start", tx_data);
            end else begin
                b = txq.pop_front();
                if (tx_data !== b) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h, expected %02h", tx_data, b);
                end
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        tx_busy  = 1'b0;
        rx_data  = 8'h00;
        wq.delete();
        txq.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        tx_busy  = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        tests_run++;
        if ({tx_data, tx_start, mem_we, mem_addr, mem_wdata, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_values: got tx_data=%02h tx_start=%b mem_we=%b addr=%0h wdata=%08h done=%b error=%b, expected all 0",
                     tx_data, tx_start, mem_we, mem_addr, mem_wdata, done, error);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int t0;
        apply_reset();
        t0 = tx_seen;
        wq.push_back(wr_t'{addr: 4'd0, data: 32'h12345678});
        wq.push_back(wr_t'{addr: 4'd1, data: 32'hDEADBEEF});
        txq.push_back(8'hAA);
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 4'd1 || mem_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL basic_write_latency: got we=%b %08h@%0h, expected we=1 deadbeef@1", mem_we, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin
            fails++;
            $display("FAIL basic_ack_timing: got tx_start=%b tx_data=%02h, expected 1 aa", tx_start, tx_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: got tx_start=%b done=%b error=%b, expected 0 1 0", tx_start, done, error);
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (tx_seen - t0 != 1 || wq.size() != 0 || done !== 1'b1) begin
            fails++;
            $display("FAIL basic_totals: got tx pulses=%0d pending writes=%0d done=%b, expected 1 0 1", tx_seen - t0, wq.size(), done);
        end
    endtask

    task automatic test_empty();
        int w0;
        apply_reset();
        w0 = wr_seen;
        txq.push_back(8'hAA);
        send_word(32'd0);
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin
            fails++;
            $display("FAIL empty_ack: got tx_start=%b tx_data=%02h, expected 1 aa", tx_start, tx_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1 || wr_seen != w0) begin
            fails++;
            $display("FAIL empty_done: got done=%b writes=%0d, expected 1 0", done, wr_seen - w0);
        end
    endtask

    task automatic test_framing_error();
        int w0;
        apply_reset();
        w0 = wr_seen;
        txq.push_back(8'h55);
        send_word(32'd1);
        send_byte(8'h11);
        // Error and ready together: the error must win.
        rx_data  = 8'h22;
        rx_ready = 1'b1;
        rx_ferr  = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        rx_ferr  = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
            fails++;
            $display("FAIL ferr_nak: got tx_start=%b tx_data=%02h, expected 1 55", tx_start, tx_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (error !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL ferr_flags: got error=%b done=%b, expected 1 0", error, done);
        end
        send_word(32'h33445566);
        send_word(32'h778899AA);
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (wr_seen != w0 || error !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL ferr_ignore: got writes=%0d error=%b done=%b, expected 0 1 0", wr_seen - w0, error, done);
        end
    endtask

    task automatic test_oversize();
        logic [31:0] d;
        int          c;
        apply_reset();
        txq.push_back(8'h55);
        send_word(32'd17);
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
            fails++;
            $display("FAIL oversize_nak: got tx_start=%b tx_data=%02h, expected 1 55", tx_start, tx_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (error !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL oversize_flags: got error=%b done=%b, expected 1 0", error, done);
        end

        apply_reset();
        txq.push_back(8'hAA);
        send_word(32'd16);
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            wq.push_back(wr_t'{addr: 4'(i), data: d});
            send_word(d);
        end
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 4'hF) begin
            fails++;
            $display("FAIL full_last_addr: got we=%b addr=%0h, expected 1 f", mem_we, mem_addr);
        end
        c = 0;
        while (done !== 1'b1 && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || wq.size() != 0) begin
            fails++;
            $display("FAIL full_done: got done=%b error=%b pending=%0d, expected 1 0 0", done, error, wq.size());
        end
    endtask

    task automatic test_tx_busy();
        int   t0;
        logic early;
        apply_reset();
        wq.push_back(wr_t'{addr: 4'd0, data: 32'hA5A50F0F});
        txq.push_back(8'hAA);
        send_word(32'd1);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_byte(8'h0F);
        tx_busy = 1'b1;
        send_byte(8'h0F);
        t0    = tx_seen;
        early = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_start === 1'b1) early = 1'b1;
            @(posedge clk); #1;
        end
        tests_run++;
        if (early !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_hold: got early tx_start=%b done=%b, expected 0 0", early, done);
        end
        tx_busy = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin
            fails++;
            $display("FAIL busy_release: got tx_start=%b tx_data=%02h, expected 1 aa", tx_start, tx_data);
        end
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (tx_seen - t0 != 1 || done !== 1'b1) begin
            fails++;
            $display("FAIL busy_single: got tx pulses=%0d done=%b, expected 1 1", tx_seen - t0, done);
        end
    endtask

    task automatic test_reset_mid_load();
        int c;
        apply_reset();
        send_word(32'd1);
        send_byte(8'h99);
        send_byte(8'h88);
        rst = 1'b1;
        #2;
        tests_run++;
        if ({tx_data, tx_start, mem_we, mem_addr, mem_wdata, done, error} !== '0) begin
            fails++;
            $display("FAIL midreset_values: got tx_start=%b mem_we=%b done=%b error=%b, expected all 0", tx_start, mem_we, done, error);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wq.push_back(wr_t'{addr: 4'd0, data: 32'hCAFEBABE});
        txq.push_back(8'hAA);
        send_word(32'd1);
        send_word(32'hCAFEBABE);
        c = 0;
        while (done !== 1'b1 && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || wq.size() != 0 || txq.size() != 0) begin
            fails++;
            $display("FAIL midreset_reload: got done=%b error=%b pending writes=%0d pending tx=%0d, expected 1 0 0 0",
                     done, error, wq.size(), txq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_framing_error();
        test_oversize();
        test_tx_busy();
        test_reset_mid_load();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Program loader on the core side of the serial link. Receives a byte stream from the `uart_rx` instance, assembles big-endian 32-bit words, and writes them sequentially into instruction memory. Once the announced word count has been written, it returns a one-byte acknowledge to the host through the `uart_tx` instance. It then raises `done`, which releases the core from its boot hold.

## Interface
Parameters:
- `ADDR_W`, default 14: instruction memory word-address width; capacity is 2^ADDR_W words.
- `ACK_BYTE`, default 8'hAA: byte sent after a successful load.
- `ERR_BYTE`, default 8'h55: byte sent on a framing error or an oversize count.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  byte from `uart_rx`; valid only while `rx_ready`=1.
- `rx_ready`  in  1  one-cycle pulse: `rx_data` is valid.
- `rx_ferr`  in  1  one-cycle pulse: framing error on the current byte.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_busy`  in  1  `uart_tx` is transmitting.
- `mem_we`  out  1  instruction memory write enable, one-cycle pulse.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `done`  out  1  load complete; held high until reset.
- `error`  out  1  load aborted; held high until reset.

## Operation
Frame format:
- 4-byte word count N, big-endian.
- N words, each 4 bytes, big-endian (first byte goes to [31:24]).

States:
- `LEN`: shift `rx_data` into a 32-bit count register on each `rx_ready`; a 2-bit byte counter tracks position.
  - On the 4th byte, compare N against 2^ADDR_W.
  - N=0: go to `ACK`.
  - N > 2^ADDR_W: go to `ERR`.
  - Otherwise: go to `DATA`.
- `DATA`: shift bytes into the word register.
  - On the 4th byte, pulse `mem_we` with `mem_addr`=word index and `mem_wdata`=assembled word.
  - Then increment the word index.
  - When the index reaches N: go to `ACK`.
- `ACK` / `ERR`: wait for `tx_busy`=0, then drive `tx_data` with `ACK_BYTE` or `ERR_BYTE` and pulse `tx_start` for one cycle.
  - `ACK` then goes to `FIN`.
  - `ERR` then goes to `HALT`.
- `FIN`: `done`=1. `HALT`: `error`=1. Both are terminal until `rst`; further bytes are ignored.

Width rules:
- The count register is 32 bits.
- The word index is ADDR_W+1 bits, so N=2^ADDR_W is legal: the last address is all-ones and the index does not wrap.

Error and boundary handling:
- `rx_ferr` in `LEN` or `DATA` discards the pending byte and goes to `ERR`, regardless of the byte counter.
- If `rx_ferr` and `rx_ready` arrive in the same cycle, the error wins.
- `rx_ready` in `ACK`, `ERR`, `FIN` or `HALT` is ignored.

## Timing
- Reset values: `tx_data`=0, `tx_start`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `error`=0. State=`LEN`; all counters 0.
- Reset asserted mid-load returns everything to the reset values immediately. Memory already written is left as is.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid in the cycle after the `rx_ready` that carried byte 3. `mem_addr`/`mem_wdata` hold until the next write.
- Last word: the cycle after its write, state=`ACK`.
  - If `tx_busy`=0 in that cycle, `tx_start` pulses in the following cycle, with `tx_data` valid in the same cycle as `tx_start`.
  - If `tx_busy`=1, `tx_start` waits until the first cycle after `tx_busy` falls.
- `done` / `error` rise in the cycle after `tx_start`.
- Throughput: one byte per `rx_ready`; back-to-back `rx_ready` pulses on consecutive cycles must be accepted.

## Structure
- Package `loader_pkg`: state enum (`LEN`, `DATA`, `ACK`, `ERR`, `FIN`, `HALT`), the `ACK_BYTE`/`ERR_BYTE` defaults, and the byte-counter width.
- One sub-module: `byte_assembler`, a 4-byte big-endian shift register with byte counter and a `word_valid` pulse. It is reused for both the count and the data words.
- `top` instantiates `uart_rx` → `uart_loader` → `uart_tx` and gates the core's reset with `done`.

## Test plan
- **Basic load:** count 00 00 00 02, then 12 34 56 78, DE AD BE EF → writes 32'h12345678@0 and 32'hDEADBEEF@1, `tx_data`=8'hAA with a single `tx_start`, then `done`=1.
- **Empty load:** count 00 00 00 00 → no `mem_we`, ACK 0xAA sent, `done`=1.
- **Framing error:** `rx_ferr` pulse during the 2nd byte of word 0 → no write, 0x55 sent, `error`=1, `done`=0; later bytes produce no writes.
- **Oversize count (ADDR_W=4):** count 17 → 0x55, `error`=1. Count 16 followed by 16 words → last write at address 4'hF, then ACK.
- **TX busy:** hold `tx_busy`=1 for 50 cycles after the last word → `tx_start` exactly 1 cycle after `tx_busy` falls, with a single pulse.
- **Reset mid-load:** assert `rst` after the 6th byte, release, then send a full 1-word frame of 00 00 00 01, CA FE BA BE → write 32'hCAFEBABE@0 and ACK; no residue from the aborted frame.
